// File: rtl/mem_rmw_ctrl.sv
// Sub-word load/store controller in front of a 32-bit word RAM with combinational read.
// Stores read-modify-write the addressed word in a single ACCESS cycle.
module mem_rmw_ctrl #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [31:0]           ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH+1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [31:0]           mask_s;
    logic                  unused_addr_s;

    function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            2'd0:    lane_mask = 32'h0000_00FF << {ofs, 3'b000};
            2'd1:    lane_mask = 32'h0000_FFFF << {ofs, 3'b000};
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] ofs, input logic uns);
        logic [31:0] sh;
        sh = word >> {ofs, 3'b000};
        case (size)
            2'd0:    load_extend = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'd1:    load_extend = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_extend = sh;
        endcase
    endfunction

    function automatic logic req_error(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            2'd0:    req_error = 1'b0;
            2'd1:    req_error = ofs[0];
            2'd2:    req_error = (ofs != 2'b00);
            default: req_error = 1'b1;
        endcase
    endfunction

    // Address bits above the RAM range are dropped, so accesses wrap modulo RAM size.
    assign unused_addr_s = ^req_addr[31:ADDR_WIDTH+2];

    // Next-state and request-latch logic.
    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    addr_d  = req_addr[ADDR_WIDTH+1:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0000_0000;
                    err_d   = req_error(req_size, req_addr[1:0]);
                    state_d = err_d ? RESP : ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (wen_q) begin
                    rdata_d = 32'h0000_0000;
                end else begin
                    rdata_d = load_extend(ram_rdata, size_q, addr_q[1:0], uns_q);
                end
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mask_s     = lane_mask(size_q, addr_q[1:0]);
    assign ram_raddr  = addr_q[ADDR_WIDTH+1:2];
    assign ram_waddr  = addr_q[ADDR_WIDTH+1:2];
    assign ram_wdata  = (ram_rdata & ~mask_s) | ((wdata_q << {addr_q[1:0], 3'b000}) & mask_s);
    // Outputs are forced low while reset is held so an in-flight store cannot write.
    assign ram_we     = ~rst & (state_q == ACCESS) & wen_q;
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = ~rst & (state_q == RESP);
    assign resp_err   = ~rst & (state_q == RESP) & err_q;
    assign resp_rdata = rst ? 32'h0000_0000 : rdata_q;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Directed bench for mem_rmw_ctrl: vector table of single transactions plus
// hand-written backpressure and mid-transaction reset sequences.
module tb_mem_rmw_ctrl;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_wen, req_unsigned;
    logic [31:0]   req_addr, req_wdata;
    logic [1:0]    req_size;
    logic          resp_valid, resp_ready, resp_err;
    logic [31:0]   resp_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [31:0]   ram_wdata, ram_rdata;

    logic [31:0] mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_wdata;
        logic [7:0]  exp_waddr;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mem_rmw_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    assign ram_rdata = mem[ram_raddr];

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_req(input vec_t v, input int idx);
        int          lat;
        int          wes;
        logic [31:0] wd;
        logic [31:0] wa;
        logic        got;
        logic [31:0] rd;
        logic        er;
        @(negedge clk);
        chk($sformatf("v%0d_req_ready", idx), {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_wen      = v.wen;
        req_addr     = v.addr;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_wdata    = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0; wes = 0; wd = 32'h0; wa = 32'h0; got = 1'b0; rd = 32'h0; er = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (ram_we) begin
                wes++;
                wd = ram_wdata;
                wa = {24'h0, ram_waddr};
            end
            if (resp_valid) begin
                got = 1'b1;
                rd  = resp_rdata;
                er  = resp_err;
            end
        end
        chk($sformatf("v%0d_resp_seen", idx), {31'd0, got}, 32'd1);
        chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_err", idx), {31'd0, er}, {31'd0, v.exp_err});
        chk($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
        chk($sformatf("v%0d_we_pulses", idx), wes, v.exp_we);
        if (v.exp_we != 0) begin
            chk($sformatf("v%0d_wdata", idx), wd, v.exp_wdata);
            chk($sformatf("v%0d_waddr", idx), wa, {24'h0, v.exp_waddr});
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk($sformatf("v%0d_ready_after", idx), {31'd0, req_ready}, 32'd1);
        chk($sformatf("v%0d_valid_after", idx), {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h1122_3344;
        mem[1] = 32'h80FF_7F01;
        mem[2] = 32'h5555_5555;

        // wen, addr, size, uns, wdata, err, rdata, lat, we, wdata, waddr
        vecs.push_back('{1'b1, 32'h001, 2'd0, 1'b0, 32'hFFFF_FFAB, 1'b0, 32'h0, 2, 1, 32'h1122_AB44, 8'h00});
        vecs.push_back('{1'b0, 32'h006, 2'd1, 1'b0, 32'h0, 1'b0, 32'hFFFF_80FF, 2, 0, 32'h0, 8'h00});
        vecs.push_back('{1'b0, 32'h006, 2'd1, 1'b1, 32'h0, 1'b0, 32'h0000_80FF, 2, 0, 32'h0, 8'h00});
        vecs.push_back('{1'b0, 32'h004, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0000_0001, 2, 0, 32'h0, 8'h00});
        vecs.push_back('{1'b0, 32'h007, 2'd0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 0, 32'h0, 8'h00});
        vecs.push_back('{1'b0, 32'h006, 2'd0, 1'b1, 32'h0, 1'b0, 32'h0000_00FF, 2, 0, 32'h0, 8'h00});
        vecs.push_back('{1'b0, 32'h005, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0000_007F, 2, 0, 32'h0, 8'h00});
        vecs.push_back('{1'b1, 32'h002, 2'd2, 1'b0, 32'h1234_5678, 1'b1, 32'h0, 1, 0, 32'h0, 8'h00});
        vecs.push_back('{1'b0, 32'h000, 2'd3, 1'b0, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 8'h00});
        vecs.push_back('{1'b0, 32'h001, 2'd1, 1'b0, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 8'h00});
        vecs.push_back('{1'b0, 32'h000, 2'd2, 1'b0, 32'h0, 1'b0, 32'h1122_AB44, 2, 0, 32'h0, 8'h00});
        vecs.push_back('{1'b1, 32'h006, 2'd1, 1'b0, 32'h1234_BEEF, 1'b0, 32'h0, 2, 1, 32'hBEEF_7F01, 8'h01});
        vecs.push_back('{1'b0, 32'h004, 2'd2, 1'b0, 32'h0, 1'b0, 32'hBEEF_7F01, 2, 0, 32'h0, 8'h00});
        vecs.push_back('{1'b1, 32'h400, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1, 32'hDEAD_BEEF, 8'h00});
        vecs.push_back('{1'b0, 32'h000, 2'd2, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 0, 32'h0, 8'h00});
        vecs.push_back('{1'b0, 32'h403, 2'd0, 1'b1, 32'h0, 1'b0, 32'h0000_00DE, 2, 0, 32'h0, 8'h00});
        vecs.push_back('{1'b0, 32'h402, 2'd1, 1'b0, 32'h0, 1'b0, 32'hFFFF_DEAD, 2, 0, 32'h0, 8'h00});

        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 32'h0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

        for (int k = 0; k < vecs.size(); k++) run_req(vecs[k], k);
        chk("mem0_after_wrap_store", mem[0], 32'hDEAD_BEEF);
        chk("mem1_after_half_store", mem[1], 32'hBEEF_7F01);

        // Backpressure: response must hold while resp_ready stays low.
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h4; req_size = 2'd2; req_unsigned = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("bp_valid_first", {31'd0, resp_valid}, 32'd1);
        chk("bp_rdata_first", resp_rdata, 32'hBEEF_7F01);
        held = resp_rdata;
        req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_valid_c%0d", c), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("bp_rdata_c%0d", c), resp_rdata, 32'hBEEF_7F01);
            chk($sformatf("bp_ready_c%0d", c), {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        chk("bp_rdata_held", resp_rdata, held);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("bp_ready_after", {31'd0, req_ready}, 32'd1);

        // Reset during the ACCESS cycle of a store.
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8; req_size = 2'd2; req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("mrst_access_we", {31'd0, ram_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst_we_in_reset", {31'd0, ram_we}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_mem_unchanged", mem[2], 32'h5555_5555);
        chk("mrst_ready_release", {31'd0, req_ready}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("mrst_no_resp_c%0d", c), {31'd0, resp_valid}, 32'd0);
        end
        chk("mrst_mem_final", mem[2], 32'h5555_5555);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
